genius_ctrl: RTL

- Moore controller that sequences the Genius game datapath.
- Generates the datapath control strobes R1, R2, E1–E4 and SEL from the datapath status flags (end_FPGA, end_User, end_time, win, match) and the synchronized ENTER button.
- Sits beside the datapath at top level on CLOCK_50.
- Flow per game: setup, then repeated FPGA-show / user-input / compare rounds, then a result screen.

---
 rtl/genius_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/genius_ctrl.sv
// Moore controller sequencing the Genius game datapath: setup, FPGA-show / user / compare rounds, result screen.
// Optional FPGA-playback watchdog is compiled in with the GENIUS_WATCHDOG_EN macro.
module genius_ctrl #(
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WD_CYCLES   = 500000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enter,
    input  logic       end_FPGA,
    input  logic       end_User,
    input  logic       end_time,
    input  logic       win,
    input  logic       match,
    output logic       R1,
    output logic       R2,
    output logic       E1,
    output logic       E2,
    output logic       E3,
    output logic       E4,
    output logic       SEL,
    output logic [2:0] state_o,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_SETUP     = 3'd1,
        S_PLAY_FPGA = 3'd2,
        S_PLAY_USER = 3'd3,
        S_CHECK     = 3'd4,
        S_ADV       = 3'd5,
        S_NEXT      = 3'd6,
        S_RESULT    = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_CYCLES);
    localparam logic [63:0]      CNT_NEED = (HOLD_CYCLES > WD_CYCLES) ? 64'(HOLD_CYCLES) : 64'(WD_CYCLES);
    localparam logic [63:0]      CNT_MAX  = (64'd1 << CNT_W) - 64'd1;

    // The shared counter must be able to reach the larger of the two limits.
    if (CNT_NEED > CNT_MAX) begin : g_cnt_w_check
        $error("genius_ctrl: CNT_W too narrow for HOLD_CYCLES/WD_CYCLES");
    end

    state_t           state_q, state_d;
    logic             enter_q;
    logic             enter_pulse;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             r1_q, r2_q, e1_q, e2_q, e3_q, e4_q, sel_q;
    logic             r1_d, r2_d, e1_d, e2_d, e3_d, e4_d, sel_d;

`ifdef GENIUS_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_C = CNT_W'(WD_CYCLES);
    logic wd_trip;
    logic fault_q, fault_d;
`endif

    assign enter_pulse = enter & ~enter_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
`ifdef GENIUS_WATCHDOG_EN
        wd_trip = 1'b0;
`endif
        case (state_q)
            S_INIT:      state_d = S_SETUP;
            S_SETUP:     if (enter_pulse) state_d = S_PLAY_FPGA;
            S_PLAY_FPGA: begin
                if (end_FPGA) begin
                    state_d = S_PLAY_USER;
`ifdef GENIUS_WATCHDOG_EN
                end else if (cnt_q == WD_C) begin
                    state_d = S_RESULT;
                    wd_trip = 1'b1;
`endif
                end
            end
            S_PLAY_USER: begin
                if (end_User)      state_d = S_CHECK;
                else if (end_time) state_d = S_RESULT;
            end
            S_CHECK:     state_d = match ? S_ADV : S_RESULT;
            S_ADV:       state_d = S_NEXT;
            S_NEXT:      state_d = win ? S_RESULT : S_PLAY_FPGA;
            S_RESULT:    if (enter_pulse && cnt_q == HOLD_C) state_d = S_INIT;
            default:     state_d = S_INIT;
        endcase

        // Counter only runs while staying in a timed state; any transition clears it.
        if (state_d == state_q) begin
            if (state_q == S_RESULT) begin
                cnt_d = (cnt_q == HOLD_C) ? cnt_q : cnt_q + CNT_W'(1);
            end
`ifdef GENIUS_WATCHDOG_EN
            if (state_q == S_PLAY_FPGA) begin
                cnt_d = (cnt_q == WD_C) ? cnt_q : cnt_q + CNT_W'(1);
            end
`endif
        end

        r1_d  = (state_d == S_INIT);
        r2_d  = (state_d == S_INIT) || (state_d == S_NEXT);
        e1_d  = (state_d == S_SETUP);
        e2_d  = (state_d == S_PLAY_USER);
        e3_d  = (state_d == S_PLAY_FPGA);
        e4_d  = (state_d == S_ADV);
        sel_d = (state_d != S_RESULT);

`ifdef GENIUS_WATCHDOG_EN
        fault_d = fault_q;
        if (wd_trip)                 fault_d = 1'b1;
        else if (state_d == S_INIT)  fault_d = 1'b0;
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            enter_q <= 1'b1;
            cnt_q   <= '0;
            r1_q    <= 1'b1;
            r2_q    <= 1'b1;
            e1_q    <= 1'b0;
            e2_q    <= 1'b0;
            e3_q    <= 1'b0;
            e4_q    <= 1'b0;
            sel_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            enter_q <= enter;
            cnt_q   <= cnt_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            e3_q    <= e3_d;
            e4_q    <= e4_d;
            sel_q   <= sel_d;
        end
    end

`ifdef GENIUS_WATCHDOG_EN
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign R1      = r1_q;
    assign R2      = r2_q;
    assign E1      = e1_q;
    assign E2      = e2_q;
    assign E3      = e3_q;
    assign E4      = e4_q;
    assign SEL     = sel_q;
    assign state_o = state_q;

endmodule
